// File: rtl/fp_to_int_converter.sv
// fp_to_int_converter: multi-cycle FP32 -> INT32/UINT32 (fcvt.w.s / fcvt.wu.s).
// Decode, align, round, saturate; valid/ready on both sides.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   in_valid/ready   operand handshake (fp_a, r_mode, is_unsigned)
//   out_valid/ready  result handshake (int_result, invalid, inexact)
//   r_mode           000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
//                    101..111 fall back to DFLT_RM
module fp_to_int_converter #(
  parameter logic [2:0] DFLT_RM = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_a,
  input  logic [2:0]  r_mode,
  input  logic        is_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_result,
  output logic        invalid,
  output logic        inexact
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ALIGN,
    ROUND,
    DONE
  } state_t;

  state_t state;

  // captured operand
  logic [31:0] a_q;
  logic [2:0]  rm_q;
  logic        uns_q;

  // decode results
  logic        s_q;
  logic [7:0]  e_q;
  logic [23:0] m_q;
  logic        nan_q;
  logic        inf_q;
  logic        zero_q;

  // align results
  logic [32:0] sh_q;
  logic        g_q;
  logic        st_q;
  logic        ovf_q;

  // decode combinational
  logic        d_zexp;
  logic [7:0]  d_e;
  logic [23:0] d_m;
  logic        d_nan;
  logic        d_inf;
  logic        d_zero;

  always_comb begin
    d_zexp = (a_q[30:23] == 8'd0);
    d_e    = d_zexp ? 8'd1 : a_q[30:23];
    d_m    = {~d_zexp, a_q[22:0]};
    d_nan  = (&a_q[30:23]) & (|a_q[22:0]);
    d_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
    d_zero = ~(|a_q[30:0]);
  end

  // align combinational: value = m * 2^(e-150)
  logic [32:0] al_sh;
  logic        al_g;
  logic        al_st;
  logic        al_ovf;
  logic [7:0]  rsh;
  logic [50:0] x;

  always_comb begin
    al_sh  = '0;
    al_g   = 1'b0;
    al_st  = 1'b0;
    al_ovf = 1'b0;
    rsh    = 8'd0;
    x      = '0;
    if (e_q >= 8'd159) begin
      // at least 2^32 for any normal mantissa
      al_ovf = 1'b1;
    end else if (e_q >= 8'd150) begin
      al_sh = {9'd0, m_q} << (e_q - 8'd150);
    end else begin
      // a 26-bit shift already pushes every
      // mantissa bit below the guard position
      rsh   = (e_q < 8'd124) ? 8'd26
                             : 8'd150 - e_q;
      x     = {m_q, 27'd0} >> rsh;
      al_sh = {9'd0, x[50:27]};
      al_g  = x[26];
      al_st = |x[25:0];
    end
  end

  // round and range check
  logic        lsb;
  logic        gs;
  logic        incr;
  logic [32:0] mag;
  logic        oor;
  logic [31:0] pos_sat;
  logic [31:0] neg_sat;
  logic [31:0] r_res;
  logic        r_inv;
  logic        r_inx;

  always_comb begin
    lsb = sh_q[0];
    gs  = g_q | st_q;
    case (rm_q)
      3'b001:  incr = 1'b0;
      3'b010:  incr = s_q & gs;
      3'b011:  incr = ~s_q & gs;
      3'b100:  incr = g_q;
      default: incr = g_q & (st_q | lsb);
    endcase
    mag = sh_q + {32'd0, incr};

    oor = ovf_q;
    if (uns_q) begin
      if (s_q) oor = oor | (mag != 33'd0);
      else     oor = oor | mag[32];
    end else begin
      if (s_q) oor = oor | (mag > 33'h0_8000_0000);
      else     oor = oor | (mag > 33'h0_7FFF_FFFF);
    end

    pos_sat = uns_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    neg_sat = uns_q ? 32'h0000_0000 : 32'h8000_0000;

    r_res = '0;
    r_inv = 1'b0;
    r_inx = 1'b0;
    if (nan_q) begin
      r_res = pos_sat;
      r_inv = 1'b1;
    end else if (inf_q | oor) begin
      r_res = s_q ? neg_sat : pos_sat;
      r_inv = 1'b1;
    end else if (zero_q) begin
      r_res = '0;
    end else begin
      // unsigned negatives only get here with mag==0
      r_res = s_q ? (32'd0 - mag[31:0]) : mag[31:0];
      r_inx = gs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      int_result <= '0;
      invalid    <= 1'b0;
      inexact    <= 1'b0;
      a_q        <= '0;
      rm_q       <= 3'b000;
      uns_q      <= 1'b0;
      s_q        <= 1'b0;
      e_q        <= '0;
      m_q        <= '0;
      nan_q      <= 1'b0;
      inf_q      <= 1'b0;
      zero_q     <= 1'b0;
      sh_q       <= '0;
      g_q        <= 1'b0;
      st_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= fp_a;
            rm_q     <= (r_mode > 3'b100) ? DFLT_RM
                                          : r_mode;
            uns_q    <= is_unsigned;
            in_ready <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          s_q    <= a_q[31];
          e_q    <= d_e;
          m_q    <= d_m;
          nan_q  <= d_nan;
          inf_q  <= d_inf;
          zero_q <= d_zero;
          state  <= ALIGN;
        end
        ALIGN: begin
          sh_q  <= al_sh;
          g_q   <= al_g;
          st_q  <= al_st;
          ovf_q <= al_ovf;
          state <= ROUND;
        end
        ROUND: begin
          int_result <= r_res;
          invalid    <= r_inv;
          inexact    <= r_inx;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int_converter.sv
// tb_fp_to_int_converter: directed vectors into a scoreboard queue,
// monitor pops and compares on each accepted result.
module tb_fp_to_int_converter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_a;
  logic [2:0]  r_mode;
  logic        is_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_result;
  logic        invalid;
  logic        inexact;

  fp_to_int_converter #(.DFLT_RM(3'b000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fp_a       (fp_a),
    .r_mode     (r_mode),
    .is_unsigned(is_unsigned),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .int_result (int_result),
    .invalid    (invalid),
    .inexact    (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        inv;
    logic        inx;
    logic [31:0] a;
    logic [2:0]  rm;
    logic        uns;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad = 0;

  // requests from the stimulus process; only the
  // monitor touches the counters
  logic        rst_chk = 1'b0;
  logic        hold_chk = 1'b0;
  logic [31:0] hold_res = '0;
  logic        hold_inv = 1'b0;
  logic        hold_inx = 1'b0;
  int          tmo_cnt = 0;
  int          tmo_seen = 0;

  always @(negedge clk) begin
    while (tmo_seen != tmo_cnt) begin
      total++;
      bad++;
      tmo_seen++;
      $display("FAIL timeout: wait bound expired (count %0d, required 0)",
               tmo_seen);
    end
    if (rst_chk) begin
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
          int_result !== 32'd0 || invalid !== 1'b0 ||
          inexact !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: got rdy=%b vld=%b res=%h inv=%b inx=%b required 1 0 00000000 0 0",
                 in_ready, out_valid, int_result, invalid, inexact);
      end
    end
    if (hold_chk) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          int_result !== hold_res || invalid !== hold_inv ||
          inexact !== hold_inx) begin
        bad++;
        $display("FAIL hold: got vld=%b rdy=%b res=%h inv=%b inx=%b required 1 0 %h %b %b",
                 out_valid, in_ready, int_result, invalid, inexact,
                 hold_res, hold_inv, hold_inx);
      end
    end
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: got res=%h inv=%b inx=%b required none",
                 int_result, invalid, inexact);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (int_result !== e.res || invalid !== e.inv ||
            inexact !== e.inx) begin
          bad++;
          $display("FAIL conv a=%h rm=%0d uns=%b: got res=%h inv=%b inx=%b required res=%h inv=%b inx=%b",
                   e.a, e.rm, e.uns, int_result, invalid, inexact,
                   e.res, e.inv, e.inx);
        end
      end
    end
  end

  // called at posedge+#1; returns at posedge+#1 after the accept edge
  task automatic send(input logic [31:0] a, input logic [2:0] rm,
                      input logic uns, input logic [31:0] res,
                      input logic inv, input logic inx,
                      input bit push);
    int n;
    exp_t e;
    n = 0;
    fp_a = a;
    r_mode = rm;
    is_unsigned = uns;
    in_valid = 1'b1;
    if (push) begin
      e.res = res; e.inv = inv; e.inx = inx;
      e.a = a; e.rm = rm; e.uns = uns;
      q.push_back(e);
    end
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      tmo_cnt++;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    fp_a = '0;
    r_mode = 3'b000;
    is_unsigned = 1'b0;
    out_ready = 1'b1;

    cyc(2);
    rst_chk = 1'b1;
    cyc(1);
    rst_chk = 1'b0;
    rst_n = 1'b1;
    cyc(1);

    // 2.5 signed, all modes
    send(32'h40200000, 3'd0, 1'b0, 32'd2, 1'b0, 1'b1, 1);
    send(32'h40200000, 3'd1, 1'b0, 32'd2, 1'b0, 1'b1, 1);
    send(32'h40200000, 3'd2, 1'b0, 32'd2, 1'b0, 1'b1, 1);
    send(32'h40200000, 3'd3, 1'b0, 32'd3, 1'b0, 1'b1, 1);
    send(32'h40200000, 3'd4, 1'b0, 32'd3, 1'b0, 1'b1, 1);
    // -2.5 signed
    send(32'hC0200000, 3'd1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, 1);
    send(32'hC0200000, 3'd2, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1, 1);
    send(32'hC0200000, 3'd0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, 1);
    // +-2^31 boundaries
    send(32'h4F000000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1);
    send(32'h4F000000, 3'd0, 1'b1, 32'h80000000, 1'b0, 1'b0, 1);
    send(32'hCF000000, 3'd0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1);
    send(32'hCF000001, 3'd0, 1'b0, 32'h80000000, 1'b1, 1'b0, 1);
    send(32'h4EFFFFFF, 3'd0, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0, 1);
    send(32'h4F7FFFFF, 3'd0, 1'b1, 32'hFFFFFF00, 1'b0, 1'b0, 1);
    send(32'h4F800000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1);
    // specials
    send(32'h7FC00000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1);
    send(32'h7FC00000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1);
    send(32'hFF800000, 3'd0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1);
    send(32'hFF800000, 3'd0, 1'b0, 32'h80000000, 1'b1, 1'b0, 1);
    send(32'h7F800000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1);
    send(32'h80000000, 3'd2, 1'b0, 32'h00000000, 1'b0, 1'b0, 1);
    // small negatives, unsigned
    send(32'hBE99999A, 3'd1, 1'b1, 32'h00000000, 1'b0, 1'b1, 1);
    send(32'hBE99999A, 3'd2, 1'b1, 32'h00000000, 1'b1, 1'b0, 1);
    send(32'hBF800000, 3'd0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1);
    send(32'hBF800000, 3'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
    // subnormal and halves
    send(32'h00000001, 3'd3, 1'b0, 32'd1, 1'b0, 1'b1, 1);
    send(32'h00000001, 3'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1);
    send(32'h3F000000, 3'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1);
    send(32'h3FC00000, 3'd0, 1'b0, 32'd2, 1'b0, 1'b1, 1);
    send(32'h3F800000, 3'd0, 1'b0, 32'd1, 1'b0, 1'b0, 1);
    // reserved modes fall back to RNE
    send(32'h40200000, 3'd7, 1'b0, 32'd2, 1'b0, 1'b1, 1);
    send(32'h40600000, 3'd5, 1'b0, 32'd4, 1'b0, 1'b1, 1);

    // in_valid while busy must be ignored
    send(32'h40400000, 3'd0, 1'b0, 32'd3, 1'b0, 1'b0, 1);
    fp_a = 32'h3F800000;
    in_valid = 1'b1;
    cyc(3);
    in_valid = 1'b0;
    cyc(3);

    // hold in DONE for 10 cycles
    out_ready = 1'b0;
    hold_res = 32'd3;
    hold_inv = 1'b0;
    hold_inx = 1'b1;
    send(32'h40200000, 3'd3, 1'b0, 32'd3, 1'b0, 1'b1, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      cyc(1);
      n++;
    end
    if (n >= 20) tmo_cnt++;
    hold_chk = 1'b1;
    cyc(10);
    hold_chk = 1'b0;
    out_ready = 1'b1;
    cyc(2);

    // reset pulse while in ROUND; result must be dropped
    send(32'h41200000, 3'd0, 1'b0, 32'd10, 1'b0, 1'b0, 0);
    cyc(2);
    rst_n = 1'b0;
    rst_chk = 1'b1;
    cyc(1);
    rst_chk = 1'b0;
    rst_n = 1'b1;
    cyc(10);

    // recovery after reset
    send(32'h41200000, 3'd0, 1'b0, 32'd10, 1'b0, 1'b0, 1);

    n = 0;
    while (q.size() != 0 && n < 200) begin
      cyc(1);
      n++;
    end
    if (n >= 200) tmo_cnt++;
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
